huffman_frame_ctrl: RTL and testbench

//  Sequencer between the symbol block memory (1-cycle read latency) and the huffman core.
//  On a start pulse it streams frame_len symbols from address 0 upward into the core, with
//  in_valid aligned to the memory output. It then waits for CNT_valid and code_valid and

---
 rtl/huffman_pkg.sv | 13 +
 rtl/hf_wdog_timer.sv | 28 ++
 rtl/huffman_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_huffman_frame_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared types and constants for the huffman frame sequencer.
package huffman_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      WAIT_RES = 2'd2,
      DONE     = 2'd3
   } hf_ctrl_state_t;

   localparam int unsigned HF_DATA_W = 8;

endpackage

// File: rtl/hf_wdog_timer.sv
// Cycle watchdog: counts while enabled, holds at TMO_CYC and flags expiry.
module hf_wdog_timer #(
   parameter int unsigned TMO_CYC = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire_c
);

   localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_expire_c = (r_cnt == CNT_W'(TMO_CYC));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !o_expire_c) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/huffman_frame_ctrl.sv
// Frame sequencer: streams symbols from block memory into the huffman core, then
// waits for the core's result strobes (or a watchdog timeout) and reports done.
module huffman_frame_ctrl
   import huffman_pkg::*;
#(
   parameter int unsigned ADDR_W  = 7,
   parameter int unsigned DATA_W  = HF_DATA_W,
   parameter int unsigned TMO_CYC = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   frame_len,
   output logic              mem_ena,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_douta,
   output logic              hf_in_valid,
   output logic [DATA_W-1:0] hf_gray_data,
   input  logic              hf_cnt_valid,
   input  logic              hf_code_valid,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [7:0]        frame_cnt
);

   localparam int unsigned    LEN_W   = ADDR_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

   hf_ctrl_state_t    r_state;
   logic [LEN_W-1:0]  r_len;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rd_v;
   logic              r_in_valid;
   logic              r_mem_ena;
   logic              r_busy;
   logic              r_done;
   logic              r_tmo_err;
   logic [7:0]        r_frame_cnt;
   logic              r_seen_cnt;
   logic              r_seen_code;

   logic [LEN_W-1:0]  w_len_clamp;
   logic              w_last;
   logic              w_seen_cnt;
   logic              w_seen_code;
   logic              w_wdog_clr;
   logic              w_wdog_en;
   logic              w_tmo_expire;

   assign w_len_clamp = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
   assign w_last      = ({1'b0, r_addr} == (r_len - LEN_W'(1)));
   // Same-cycle strobes count alongside previously latched ones
   assign w_seen_cnt  = r_seen_cnt  | hf_cnt_valid;
   assign w_seen_code = r_seen_code | hf_code_valid;
   assign w_wdog_clr  = (r_state != WAIT_RES);
   assign w_wdog_en   = (r_state == WAIT_RES);

   hf_wdog_timer #(
      .TMO_CYC (TMO_CYC)
   ) u_wdog (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_wdog_clr),
      .i_enable   (w_wdog_en),
      .o_expire_c (w_tmo_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_addr      <= '0;
         r_rd_v      <= 1'b0;
         r_in_valid  <= 1'b0;
         r_mem_ena   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_tmo_err   <= 1'b0;
         r_frame_cnt <= '0;
         r_seen_cnt  <= 1'b0;
         r_seen_code <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         // Valid trails the read request by the memory's one-cycle latency
         r_in_valid <= r_rd_v;
         if (r_state != IDLE) begin
            r_seen_cnt  <= w_seen_cnt;
            r_seen_code <= w_seen_code;
         end

         if (abort && (r_state != IDLE)) begin
            r_state   <= IDLE;
            r_rd_v    <= 1'b0;
            r_mem_ena <= 1'b0;
            r_busy    <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (start && (frame_len != '0)) begin
                     r_len       <= w_len_clamp;
                     r_addr      <= '0;
                     r_rd_v      <= 1'b1;
                     r_mem_ena   <= 1'b1;
                     r_busy      <= 1'b1;
                     r_tmo_err   <= 1'b0;
                     r_seen_cnt  <= 1'b0;
                     r_seen_code <= 1'b0;
                     r_state     <= FETCH;
                  end
               end
               FETCH: begin
                  if (w_last) begin
                     r_rd_v    <= 1'b0;
                     r_mem_ena <= 1'b0;
                     r_state   <= WAIT_RES;
                  end else begin
                     r_addr <= r_addr + ADDR_W'(1);
                  end
               end
               WAIT_RES: begin
                  // A result arriving on the expiry cycle still counts as success
                  if (w_seen_cnt && w_seen_code) begin
                     r_done      <= 1'b1;
                     r_frame_cnt <= r_frame_cnt + 8'(1);
                     r_state     <= DONE;
                  end else if (w_tmo_expire) begin
                     r_tmo_err   <= 1'b1;
                     r_done      <= 1'b1;
                     r_frame_cnt <= r_frame_cnt + 8'(1);
                     r_state     <= DONE;
                  end
               end
               DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign mem_ena      = r_mem_ena;
   assign mem_addr     = r_addr;
   assign hf_in_valid  = r_in_valid;
   assign hf_gray_data = mem_douta;
   assign busy         = r_busy;
   assign done         = r_done;
   assign timeout_err  = r_tmo_err;
   assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// Bench for huffman_frame_ctrl: memory and huffman-core models, beat scoreboard,
// table of frame scenarios plus abort / zero-length / reset sequences.
module tb_huffman_frame_ctrl;

   localparam int unsigned ADDR_W  = 7;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned TMO_CYC = 16;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [ADDR_W:0]   frame_len;
   logic              mem_ena;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_douta;
   logic              hf_in_valid;
   logic [DATA_W-1:0] hf_gray_data;
   logic              hf_cnt_valid;
   logic              hf_code_valid;
   logic              busy;
   logic              done;
   logic              timeout_err;
   logic [7:0]        frame_cnt;

   huffman_frame_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .frame_len     (frame_len),
      .mem_ena       (mem_ena),
      .mem_addr      (mem_addr),
      .mem_douta     (mem_douta),
      .hf_in_valid   (hf_in_valid),
      .hf_gray_data  (hf_gray_data),
      .hf_cnt_valid  (hf_cnt_valid),
      .hf_code_valid (hf_code_valid),
      .busy          (busy),
      .done          (done),
      .timeout_err   (timeout_err),
      .frame_cnt     (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Symbol memory with unique content per address, one-cycle read latency
   logic [DATA_W-1:0] mem [128];
   initial for (int a = 0; a < 128; a++) mem[a] = 8'(a) ^ 8'h5A;
   always @(posedge clk) if (mem_ena) mem_douta <= mem[mem_addr];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard and core-model state (monitor-owned except cfg_* and frame_id)
   logic [DATA_W-1:0] exp_q[$];
   int  frame_id = 0, seen_id = 0;
   int  cyc = 0, beats_seen = 0, since_last = 0, done_cnt = 0, done_lat = -1, first_cyc = -1;
   bit  last_seen = 0;
   int  cur_len = 0, cfg_cnt = -1, cfg_code = -1;
   bit  cfg_early = 0;

   initial begin
      logic [DATA_W-1:0] d;
      hf_cnt_valid  = 1'b0;
      hf_code_valid = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (frame_id != seen_id) begin
            seen_id = frame_id; beats_seen = 0; last_seen = 0; since_last = 0;
            done_cnt = 0; done_lat = -1; first_cyc = -1; exp_q.delete();
         end
         if (hf_in_valid) begin
            if (exp_q.size() == 0) begin
               chk("beat_extra", beats_seen + 1, cur_len);
            end else begin
               d = exp_q.pop_front();
               chk("beat_data", int'(hf_gray_data), int'(d));
            end
            if (beats_seen == 0) first_cyc = cyc;
            beats_seen++;
            if (beats_seen == cur_len) begin
               last_seen  = 1;
               since_last = 0;
            end
         end else if (last_seen) begin
            since_last++;
         end
         if (done) begin
            done_cnt++;
            done_lat = since_last;
         end
         hf_cnt_valid  = (last_seen && since_last == cfg_cnt) ||
                         (cfg_early && hf_in_valid && beats_seen == 3);
         hf_code_valid = last_seen && since_last == cfg_code;
      end
   end

   typedef struct {
      int len;
      int cnt_dly;
      int code_dly;
      bit early;
      bit repulse;
      int exp_beats;
      bit exp_tmo;
      int exp_lat;
   } vec_t;

   int exp_fc = 0;

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic new_frame();
      frame_id++;
      step();
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int start_cyc;
      new_frame();
      cfg_cnt = v.cnt_dly; cfg_code = v.code_dly; cfg_early = v.early; cur_len = v.exp_beats;
      for (int a = 0; a < v.exp_beats; a++) exp_q.push_back(mem[a]);
      start = 1'b1; frame_len = 8'(v.len); start_cyc = cyc;
      step();
      start = 1'b0; frame_len = '0;
      if (v.repulse) begin
         repeat (4) step();
         start = 1'b1; frame_len = 8'd50;
         step();
         start = 1'b0; frame_len = '0;
      end
      for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
      chk({tag, "_done_seen"}, done_cnt, 1);
      repeat (3) step();
      exp_fc = (exp_fc + 1) % 256;
      chk({tag, "_beats"}, beats_seen, v.exp_beats);
      chk({tag, "_q_empty"}, exp_q.size(), 0);
      chk({tag, "_first_lat"}, first_cyc - start_cyc, 2);
      chk({tag, "_done_lat"}, done_lat, v.exp_lat);
      chk({tag, "_done_once"}, done_cnt, 1);
      chk({tag, "_tmo"}, int'(timeout_err), int'(v.exp_tmo));
      chk({tag, "_frame_cnt"}, int'(frame_cnt), exp_fc);
      chk({tag, "_busy"}, int'(busy), 0);
      cfg_cnt = -1; cfg_code = -1; cfg_early = 0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_mem_ena"}, int'(mem_ena), 0);
      chk({tag, "_mem_addr"}, int'(mem_addr), 0);
      chk({tag, "_in_valid"}, int'(hf_in_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_tmo"}, int'(timeout_err), 0);
      chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
   endtask

   initial begin
      vec_t vecs[5];
      vec_t v;
      //          len  cnt code early rep beats tmo lat
      vecs[0] = '{100,  5,   9,  0,   0,  100,  0,  10};
      vecs[1] = '{  1,  3,   3,  0,   0,    1,  0,   4};
      vecs[2] = '{  5,  4,  -1,  0,   0,    5,  1,  17};
      vecs[3] = '{  8, -1,   6,  1,   0,    8,  0,   7};
      vecs[4] = '{ 20,  2,   2,  0,   1,   20,  0,   3};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs("por");
      step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      // Zero-length start is ignored
      new_frame();
      start = 1'b1; frame_len = '0;
      step();
      start = 1'b0;
      repeat (4) step();
      chk("len0_busy", int'(busy), 0);
      chk("len0_mem_ena", int'(mem_ena), 0);
      chk("len0_beats", beats_seen, 0);
      chk("len0_done", done_cnt, 0);
      chk("len0_frame_cnt", int'(frame_cnt), exp_fc);

      // Abort at beat 40 of 100
      new_frame();
      cur_len = 100;
      for (int a = 0; a < 100; a++) exp_q.push_back(mem[a]);
      start = 1'b1; frame_len = 8'd100;
      step();
      start = 1'b0; frame_len = '0;
      for (int i = 0; i < 500 && beats_seen < 40; i++) step();
      chk("abort_reach", beats_seen, 40);
      abort = 1'b1;
      step();
      abort = 1'b0;
      repeat (4) step();
      chk("abort_beats", beats_seen, 41);
      chk("abort_in_valid", int'(hf_in_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", done_cnt, 0);
      chk("abort_frame_cnt", int'(frame_cnt), exp_fc);

      v = '{10, 3, 5, 0, 0, 10, 0, 6};
      run_frame(v, "post_abort");

      // Async reset at beat 50, then a clamped frame
      new_frame();
      cur_len = 100;
      for (int a = 0; a < 100; a++) exp_q.push_back(mem[a]);
      start = 1'b1; frame_len = 8'd100;
      step();
      start = 1'b0; frame_len = '0;
      for (int i = 0; i < 500 && beats_seen < 50; i++) step();
      chk("rst_reach", beats_seen, 50);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("midrst");
      repeat (3) step();
      rst_n = 1'b1;
      exp_fc = 0;
      step();

      v = '{200, 4, 7, 0, 0, 128, 0, 8};
      run_frame(v, "clamp");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
